// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC core: opcode and phase encodings,
// the controller strobe bundle and the ALU-operation classifier.
package risc_pkg;

    // Instruction opcodes (3-bit field of the instruction register)
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Instruction-cycle phases, stepped in this order and wrapping
    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    localparam int NUM_PHASES = 8;

    // Control strobes produced by the controller, excluding halt
    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic wr;
        logic data_e;
    } strobes_t;

    // True for opcodes whose result is produced by the ALU and loaded into AC
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Controller-side bus: opcode/flag/enable inputs and per-phase control strobes.
interface risc_controller_if;
    logic       enable;
    logic [2:0] opcode;
    logic       zero;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       ld_pc;
    logic       ld_ac;
    logic       wr;
    logic       data_e;
    logic       halt;
    logic [2:0] phase;

    // Controller view: consumes opcode/zero/enable, drives strobes
    modport master (
        input  enable, opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );

    // Datapath view: supplies opcode/zero/enable, receives strobes
    modport slave (
        output enable, opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );
endinterface

// File: rtl/risc_phase_counter.sv
// 3-bit wrapping phase counter. Advances once per enabled clock unless frozen.
module risc_phase_counter
    import risc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       freeze,
    output logic [2:0] phase
);

    logic [2:0] phase_reg;
    logic [2:0] phase_next;

    // Next phase: step forward only when enabled and not frozen; STORE wraps to INST_ADDR
    always_comb begin
        phase_next = phase_reg;
        if (enable && !freeze) begin
            phase_next = phase_reg + 3'd1;
        end
    end

    // Phase register with asynchronous reset to INST_ADDR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= PH_INST_ADDR;
        end else begin
            phase_reg <= phase_next;
        end
    end

    assign phase = phase_reg;

endmodule

// File: rtl/risc_controller.sv
// Phase sequencer for the 8-bit RISC core: holds the sticky halt latch and
// decodes phase/opcode/zero into the per-phase datapath strobes.
module risc_controller
    import risc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    risc_controller_if.master  bus
);

    logic [2:0]            phase_reg;
    logic                  halt_reg;
    logic                  halt_next;
    logic [NUM_PHASES-1:0] phase_hot;
    logic                  aluop;
    logic                  hlt_in_op_addr;
    strobes_t              strobes;

    // Counter freezes once halted; the halt latch is set on the edge leaving
    // OP_ADDR, so the frozen phase is OP_FETCH.
    risc_phase_counter u_phase_counter (
        .clk    (clk),
        .rst    (rst),
        .enable (bus.enable),
        .freeze (halt_reg),
        .phase  (phase_reg)
    );

    // One-hot view of the registered phase keeps the decode below readable
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_phase_hot
            assign phase_hot[gi] = (phase_reg == 3'(gi));
        end
    endgenerate

    assign aluop          = is_aluop(bus.opcode);
    assign hlt_in_op_addr = phase_hot[PH_OP_ADDR] && (bus.opcode == OP_HLT);

    // Halt latch next state: sticky once set, only reset clears it
    always_comb begin
        halt_next = halt_reg;
        if (bus.enable && hlt_in_op_addr) begin
            halt_next = 1'b1;
        end
    end

    // Halt latch register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_reg <= 1'b0;
        end else begin
            halt_reg <= halt_next;
        end
    end

    // Strobe decode from registered phase, opcode and zero; forced low when halted
    always_comb begin
        strobes        = '0;
        strobes.sel    = phase_hot[PH_INST_ADDR] | phase_hot[PH_INST_FETCH]
                       | phase_hot[PH_INST_LOAD] | phase_hot[PH_IDLE];
        strobes.rd     = phase_hot[PH_INST_FETCH] | phase_hot[PH_INST_LOAD]
                       | phase_hot[PH_IDLE]
                       | (aluop & (phase_hot[PH_OP_FETCH] | phase_hot[PH_ALU_OP]
                                   | phase_hot[PH_STORE]));
        strobes.ld_ir  = phase_hot[PH_INST_LOAD] | phase_hot[PH_IDLE];
        strobes.inc_pc = phase_hot[PH_OP_ADDR]
                       | (phase_hot[PH_ALU_OP] & (bus.opcode == OP_SKZ) & bus.zero);
        strobes.ld_pc  = (bus.opcode == OP_JMP) & (phase_hot[PH_ALU_OP] | phase_hot[PH_STORE]);
        strobes.ld_ac  = aluop & phase_hot[PH_STORE];
        strobes.wr     = (bus.opcode == OP_STO) & phase_hot[PH_STORE];
        strobes.data_e = (bus.opcode == OP_STO) & (phase_hot[PH_ALU_OP] | phase_hot[PH_STORE]);
        if (halt_reg) begin
            strobes = '0;
        end
    end

    assign bus.sel    = strobes.sel;
    assign bus.rd     = strobes.rd;
    assign bus.ld_ir  = strobes.ld_ir;
    assign bus.inc_pc = strobes.inc_pc;
    assign bus.ld_pc  = strobes.ld_pc;
    assign bus.ld_ac  = strobes.ld_ac;
    assign bus.wr     = strobes.wr;
    assign bus.data_e = strobes.data_e;
    assign bus.halt   = halt_reg | hlt_in_op_addr;
    assign bus.phase  = phase_reg;

endmodule

// File: tb/tb_risc_controller.sv
// Bench for risc_controller: directed scenarios plus randomized opcode/zero/
// enable/reset traffic, compared every cycle against a behavioural model.
module tb_risc_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    risc_controller_if bus();

    risc_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state: which phase the instruction cycle is in, and halted flag
    int m_phase  = 0;
    bit m_halted = 1'b0;

    // Output vector layout: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase[2:0]}
    function automatic logic [11:0] dut_vec();
        return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac,
                bus.wr, bus.data_e, bus.halt, bus.phase};
    endfunction

    // Expected outputs from the phase table rules
    function automatic logic [11:0] exp_vec(input int ph, input bit halted, input int op, input bit z);
        bit alu, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
        logic [2:0] p;
        p = 3'(ph);
        if (halted) return {8'b0, 1'b1, p};
        alu    = (op == 2) || (op == 3) || (op == 4) || (op == 5);
        sel    = (ph <= 3);
        rd     = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        ld_ir  = (ph == 2) || (ph == 3);
        inc_pc = (ph == 4) || (ph == 6 && op == 1 && z);
        ld_pc  = (ph >= 6) && (op == 7);
        ld_ac  = (ph == 7) && alu;
        wr     = (ph == 7) && (op == 6);
        data_e = (ph >= 6) && (op == 6);
        halt   = (ph == 4) && (op == 0);
        return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h (phase %0d)", tag, obs, exp, m_phase);
    endtask

    task automatic check_now(input string tag);
        chk(tag, 32'(dut_vec()), 32'(exp_vec(m_phase, m_halted, int'(bus.opcode), bus.zero)));
    endtask

    // Advance to just after the next rising edge, updating the model with the inputs seen there
    task automatic tick();
        @(posedge clk);
        if (!rst && bus.enable && !m_halted) begin
            if (m_phase == 4 && bus.opcode == 3'd0) m_halted = 1'b1;
            m_phase = (m_phase + 1) % 8;
        end
        #1;
    endtask

    task automatic step(input string tag);
        #1;
        check_now(tag);
        tick();
    endtask

    task automatic run_to(input int ph);
        for (int i = 0; i < 20 && m_phase != ph; i++) step("run");
        chk("reach_phase", 32'(bus.phase), 32'(ph));
    endtask

    // Assert reset between clock edges and confirm outputs react before the next edge
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        m_phase  = 0;
        m_halted = 1'b0;
        #1;
        check_now(tag);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // first edge after release advances only if enabled
        if (bus.enable) m_phase = 1;
    endtask

    int cnt_sel, cnt_rd, cnt_ldir, cnt_inc, cnt_ldac, cnt_other;

    initial begin
        bus.enable = 1'b1;
        bus.opcode = 3'd2;
        bus.zero   = 1'b0;

        // Reset state
        #12;
        check_now("reset_state");
        chk("reset_sel", 32'(bus.sel), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_phase = 1;
        run_to(0);

        // ADD over one full instruction: strobe pulse counts
        cnt_sel = 0; cnt_rd = 0; cnt_ldir = 0; cnt_inc = 0; cnt_ldac = 0; cnt_other = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_now("add_cycle");
            cnt_sel   += int'(bus.sel);
            cnt_rd    += int'(bus.rd);
            cnt_ldir  += int'(bus.ld_ir);
            cnt_inc   += int'(bus.inc_pc);
            cnt_ldac  += int'(bus.ld_ac);
            cnt_other += int'(bus.wr) + int'(bus.ld_pc) + int'(bus.data_e) + int'(bus.halt);
            tick();
        end
        chk("add_sel_cnt",   32'(cnt_sel),   32'd4);
        chk("add_rd_cnt",    32'(cnt_rd),    32'd6);
        chk("add_ldir_cnt",  32'(cnt_ldir),  32'd2);
        chk("add_inc_cnt",   32'(cnt_inc),   32'd1);
        chk("add_ldac_cnt",  32'(cnt_ldac),  32'd1);
        chk("add_other_cnt", 32'(cnt_other), 32'd0);
        chk("add_wrap",      32'(bus.phase), 32'd0);

        // SKZ with zero=1 then zero=0
        for (int z = 1; z >= 0; z--) begin
            bus.opcode = 3'd1;
            bus.zero   = 1'(z);
            cnt_inc = 0;
            for (int i = 0; i < 8; i++) begin
                #1;
                check_now("skz_cycle");
                cnt_inc += int'(bus.inc_pc);
                tick();
            end
            chk(z == 1 ? "skz_inc_z1" : "skz_inc_z0", 32'(cnt_inc), (z == 1) ? 32'd2 : 32'd1);
        end

        // STO and JMP full instructions
        bus.opcode = 3'd6;
        run_to(6);
        chk("sto_p6_data_e", 32'(bus.data_e), 32'd1);
        chk("sto_p6_wr",     32'(bus.wr),     32'd0);
        step("sto_p6");
        chk("sto_p7_wr",     32'(bus.wr),     32'd1);
        run_to(0);
        bus.opcode = 3'd7;
        run_to(6);
        chk("jmp_p6_ld_pc", 32'(bus.ld_pc), 32'd1);
        step("jmp_p6");
        chk("jmp_p7_ld_pc", 32'(bus.ld_pc), 32'd1);
        run_to(0);

        // HLT: halt in OP_ADDR, then frozen at OP_FETCH
        bus.opcode = 3'd0;
        run_to(4);
        chk("hlt_p4_halt", 32'(bus.halt), 32'd1);
        step("hlt_p4");
        for (int i = 0; i < 22; i++) begin
            bus.opcode = 3'($urandom_range(0, 7));
            bus.zero   = 1'($urandom_range(0, 1));
            step("halted");
        end
        chk("halted_phase", 32'(bus.phase), 32'd5);
        async_reset("hlt_reset");
        chk("hlt_reset_halt", 32'(bus.halt), 32'd0);
        bus.opcode = 3'd2;
        run_to(0);

        // ADD with enable dropped while in STORE
        run_to(7);
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("pause_ld_ac", 32'(bus.ld_ac), 32'd1);
            chk("pause_phase", 32'(bus.phase), 32'd7);
            tick();
        end
        bus.enable = 1'b1;
        step("pause_resume");
        chk("pause_wrap", 32'(bus.phase), 32'd0);

        // Asynchronous reset in ALU_OP during STO
        bus.opcode = 3'd6;
        run_to(6);
        #1;
        check_now("sto_p6_pre");
        async_reset("sto_async_reset");
        run_to(0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (m_phase < 4) bus.opcode = 3'($urandom_range(0, 7));
            bus.zero   = 1'($urandom_range(0, 1));
            bus.enable = ($urandom_range(0, 9) != 0);
            if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0) begin
                async_reset("rand_reset");
            end else begin
                step("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/risc_controller.md
# risc_controller

Phase sequencer for the 8-bit RISC core. It steps a fixed eight-phase instruction cycle and decodes the 3-bit instruction opcode (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP) into the per-phase control strobes. Those strobes drive the address mux, memory, instruction register, program counter, accumulator and data bus driver around the ALU. It samples the ALU's accumulator-zero flag for SKZ and holds the core in a sticky halted state on HLT.

## Interface
- Parameters: none. Opcode width is fixed at 3 bits and the phase count at 8.
- clk  in  1  core clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  when 0, the phase register and halt latch hold; strobes keep decoding from held state
- opcode  in  3  instruction-register opcode field; stable from phase OP_ADDR through STORE
- zero  in  1  ALU accumulator-is-zero flag, combinational
- sel  out  1  address mux: 1 selects PC, 0 selects IR operand address
- rd  out  1  memory read enable
- ld_ir  out  1  instruction register load
- inc_pc  out  1  program counter increment
- ld_pc  out  1  program counter parallel load (jump)
- ld_ac  out  1  accumulator load from ALU output
- wr  out  1  memory write strobe
- data_e  out  1  accumulator-to-data-bus driver enable
- halt  out  1  core halted
- phase  out  3  current phase, for debug and bench

## Operation
- Opcode encodings: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP is true for ADD, AND, XOR and LDA.
- Phases 0–7 in order: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE. STORE wraps to INST_ADDR.
- Only strobes listed as 1 in a phase are asserted; all other strobes are 0.
- INST_ADDR: sel=1.
- INST_FETCH: sel=1, rd=1.
- INST_LOAD: sel=1, rd=1, ld_ir=1.
- IDLE: sel=1, rd=1, ld_ir=1.
- OP_ADDR: inc_pc=1. halt=1 if opcode=HLT.
- OP_FETCH: rd=ALUOP.
- ALU_OP: rd=ALUOP; inc_pc=(SKZ and zero); ld_pc=JMP; data_e=STO.
- STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
- Halt latch: set on the rising edge that leaves OP_ADDR with opcode=HLT and enable=1.
- Halted: the phase register freezes at OP_FETCH. All strobes except halt are forced to 0. halt=1 continuously.
- Only rst clears the halted state.
- Strobes are a combinational decode of the registered phase, the halt latch, opcode and zero. There are no feedback paths from the strobes.

## Timing
- Reset, asynchronous: phase=INST_ADDR and the halt latch is cleared.
- Outputs during reset: sel=1, phase=0, all other outputs 0.
- First advance to INST_FETCH occurs on the first rising edge with rst=0 and enable=1.
- One phase per enabled clock, so one instruction takes 8 enabled cycles.
- SKZ sees zero during ALU_OP. inc_pc is then high in OP_ADDR and in ALU_OP, giving a PC advance of 2 when zero=1 and 1 otherwise.
- JMP: ld_pc is high for 2 cycles (ALU_OP and STORE).
- STO: data_e is high in ALU_OP and STORE; wr is high only in STORE, so data is on the bus one cycle before and during the write.
- HLT: halt goes high combinationally in OP_ADDR and stays high from the next edge onward.
- enable=0 in any phase: the phase register holds and the strobes for that phase stay asserted for every held cycle. A paused STORE holds wr high; the memory must tolerate repeated identical writes.
- Reset mid-instruction: immediately returns to INST_ADDR, abandoning the instruction. No partial write is guaranteed beyond the cycles already elapsed.
- Opcode changes outside OP_ADDR..STORE do not affect the phase sequence.

## Structure
- Shared package risc_pkg holds:
  - opcode localparams (OP_HLT..OP_JMP), 3 bits;
  - phase encoding localparams (PH_INST_ADDR..PH_STORE), 3 bits;
  - an is_aluop function.
  The ALU and this block both import it.
- One sub-module, risc_phase_counter: 3-bit wrapping counter with enable, freeze (from the halt latch) and asynchronous active-high reset.
- The top level of risc_controller holds the halt latch and the strobe decode.

## Test plan
- Reset, then opcode=ADD (2) with enable=1: phase runs 0..7 and wraps. Over 8 cycles, sel is high 4 cycles, rd 6, ld_ir 2, inc_pc 1, ld_ac 1, and wr, ld_pc, data_e, halt stay 0.
- opcode=SKZ (1): with zero=1, inc_pc is high in OP_ADDR and ALU_OP (2 pulses); with zero=0, inc_pc pulses once; rd and ld_ac stay 0 in phases 5–7.
- opcode=STO (6): data_e is high in phases 6–7, wr only in phase 7, rd=0 in phases 5–7. opcode=JMP (7): ld_pc is high in phases 6–7.
- opcode=HLT (0): halt rises in phase 4, then phase stays at 5 for 20+ cycles with all strobes 0 and halt=1. Asserting rst returns phase=0, halt=0, sel=1.
- ADD, enable dropped for 3 cycles while in STORE: phase stays 7 and ld_ac stays high for 3 extra cycles, then wraps to 0 when enable returns.
- rst asserted asynchronously mid-cycle in phase 6 with STO: outputs go to reset values before the next clock edge (wr=0, data_e=0, sel=1).
